// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a valid/ready handshake, flush (bubble insertion) and an
// optional two-entry skid buffer that makes in_ready depend on registered state only.
module pipe_stage_skid #(
   parameter int unsigned CTRL_WIDTH = 32'd18,
   parameter int unsigned DATA_WIDTH = 32'd175,
   parameter int unsigned SKID       = 32'd1,
   parameter int unsigned FLUSH_DATA = 32'd1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            count
);

   localparam bit HAS_SKID  = (SKID != 32'd0);
   localparam bit CLR_DATA  = (FLUSH_DATA != 32'd0);

   // Encoding is {S.valid, M.valid}; S is only ever valid while M is valid.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } state_e;

   state_e                state_q, state_d;
   logic [CTRL_WIDTH-1:0] m_ctrl_q, m_ctrl_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic [CTRL_WIDTH-1:0] s_ctrl_q, s_ctrl_d;
   logic [DATA_WIDTH-1:0] s_data_q, s_data_d;
   logic                  m_valid_s;
   logic                  s_valid_s;
   logic                  accept_s;
   logic                  drain_s;

   assign m_valid_s = (state_q == ST_ONE) || (state_q == ST_FULL);
   assign s_valid_s = (state_q == ST_FULL);

   // With the skid buffer, ready never looks at out_ready, which breaks the ready chain.
   assign in_ready  = HAS_SKID ? (!s_valid_s && !rst)
                               : ((!m_valid_s || out_ready) && !rst);
   assign accept_s  = in_valid && in_ready;
   assign drain_s   = m_valid_s && out_ready;

   assign out_valid = m_valid_s;
   assign out_ctrl  = m_ctrl_q;
   assign out_data  = m_data_q;
   assign count     = {1'b0, m_valid_s} + {1'b0, s_valid_s};

   // Next-state and next-entry selection for the M/S pair.
   always_comb begin
      state_d  = state_q;
      m_ctrl_d = m_ctrl_q;
      m_data_d = m_data_q;
      s_ctrl_d = s_ctrl_q;
      s_data_d = s_data_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept_s) begin
               m_ctrl_d = in_ctrl;
               m_data_d = in_data;
               state_d  = ST_ONE;
            end else begin
               state_d  = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (accept_s && drain_s) begin
               m_ctrl_d = in_ctrl;
               m_data_d = in_data;
            end else if (drain_s) begin
               m_ctrl_d = {CTRL_WIDTH{1'b0}};
               state_d  = ST_EMPTY;
            end else if (accept_s && HAS_SKID) begin
               s_ctrl_d = in_ctrl;
               s_data_d = in_data;
               state_d  = ST_FULL;
            end else begin
               state_d  = ST_ONE;
            end
         end
         ST_FULL: begin
            if (drain_s) begin
               m_ctrl_d = s_ctrl_q;
               m_data_d = s_data_q;
               s_ctrl_d = {CTRL_WIDTH{1'b0}};
               state_d  = ST_ONE;
            end else begin
               state_d  = ST_FULL;
            end
         end
         default: begin
            state_d  = ST_EMPTY;
            m_ctrl_d = {CTRL_WIDTH{1'b0}};
            s_ctrl_d = {CTRL_WIDTH{1'b0}};
         end
      endcase
   end

   // State and entry registers; rst and flush clear identically and win over the handshake.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q  <= ST_EMPTY;
         m_ctrl_q <= {CTRL_WIDTH{1'b0}};
         s_ctrl_q <= {CTRL_WIDTH{1'b0}};
         if (CLR_DATA) begin
            m_data_q <= {DATA_WIDTH{1'b0}};
            s_data_q <= {DATA_WIDTH{1'b0}};
         end else begin
            m_data_q <= m_data_q;
            s_data_q <= s_data_q;
         end
      end else begin
         state_q  <= state_d;
         m_ctrl_q <= m_ctrl_d;
         m_data_q <= m_data_d;
         s_ctrl_q <= s_ctrl_d;
         s_data_q <= s_data_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random checks of pipe_stage_skid with SKID=1 and SKID=0 instances.
module tb_pipe_stage_skid;

   localparam int CW = 18;
   localparam int DW = 175;
   localparam int EW = CW + DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;

   logic          s1_in_valid = 1'b0, s1_in_ready, s1_out_valid, s1_out_ready = 1'b0;
   logic [CW-1:0] s1_in_ctrl = '0, s1_out_ctrl;
   logic [DW-1:0] s1_in_data = '0, s1_out_data;
   logic [1:0]    s1_count;

   logic          s0_in_valid = 1'b0, s0_in_ready, s0_out_valid, s0_out_ready = 1'b0;
   logic [CW-1:0] s0_in_ctrl = '0, s0_out_ctrl;
   logic [DW-1:0] s0_in_data = '0, s0_out_data;
   logic [1:0]    s0_count;

   int n_cmp = 0;
   int n_err = 0;

   logic [EW-1:0] q1[$];
   logic [EW-1:0] q0[$];

   always #5 clk = ~clk;

   pipe_stage_skid #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(1), .FLUSH_DATA(1)) u_s1 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_ctrl(s1_in_ctrl), .in_data(s1_in_data),
      .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_ctrl(s1_out_ctrl),
      .out_data(s1_out_data), .count(s1_count));

   pipe_stage_skid #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(0), .FLUSH_DATA(1)) u_s0 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_ctrl(s0_in_ctrl), .in_data(s0_in_data),
      .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_ctrl(s0_out_ctrl),
      .out_data(s0_out_data), .count(s0_count));

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d = '0;
      for (int k = 0; k < 6; k++) d = (d << 32) | DW'($urandom);
      return d;
   endfunction

   initial begin
      // reset state
      tick();
      chk("rst_out_valid", s1_out_valid, 0);
      chk("rst_out_ctrl", s1_out_ctrl, 0);
      chk("rst_out_data", s1_out_data, 0);
      chk("rst_count", s1_count, 0);
      chk("rst_in_ready", s1_in_ready, 0);
      chk("rst_s0_in_ready", s0_in_ready, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", s1_in_ready, 1);
      chk("post_rst_s0_in_ready", s0_in_ready, 1);

      // streaming, SKID=1
      s1_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s1_in_valid = 1'b1;
         s1_in_ctrl  = CW'(i + 1);
         s1_in_data  = DW'(32'hA0 + i);
         tick();
         chk("stream_valid", s1_out_valid, 1);
         chk("stream_ctrl", s1_out_ctrl, 256'(i + 1));
         chk("stream_data", s1_out_data, 256'(32'hA0 + i));
         chk("stream_in_ready", s1_in_ready, 1);
      end
      s1_in_valid = 1'b0;
      tick();
      chk("stream_end_valid", s1_out_valid, 0);
      chk("stream_end_ctrl", s1_out_ctrl, 0);
      chk("stream_end_count", s1_count, 0);

      // backpressure, SKID=1
      s1_out_ready = 1'b0;
      s1_in_valid  = 1'b1;
      s1_in_ctrl   = 18'd1; s1_in_data = DW'(32'hB1);
      tick();
      chk("bp1_count", s1_count, 1);
      chk("bp1_in_ready", s1_in_ready, 1);
      s1_in_ctrl   = 18'd2; s1_in_data = DW'(32'hB2);
      tick();
      chk("bp2_count", s1_count, 2);
      chk("bp2_in_ready", s1_in_ready, 0);
      chk("bp2_ctrl", s1_out_ctrl, 1);
      s1_in_ctrl   = 18'd3; s1_in_data = DW'(32'hB3);
      tick();
      chk("bp3_count", s1_count, 2);
      chk("bp3_ctrl", s1_out_ctrl, 1);
      chk("bp3_data", s1_out_data, 256'h B1);
      s1_out_ready = 1'b1;
      tick();
      chk("bp_drain2_ctrl", s1_out_ctrl, 2);
      chk("bp_drain2_data", s1_out_data, 256'hB2);
      chk("bp_drain2_count", s1_count, 1);
      chk("bp_drain2_in_ready", s1_in_ready, 1);
      tick();
      s1_in_valid = 1'b0;
      chk("bp_drain3_ctrl", s1_out_ctrl, 3);
      chk("bp_drain3_data", s1_out_data, 256'hB3);
      chk("bp_drain3_count", s1_count, 1);
      tick();
      chk("bp_empty_valid", s1_out_valid, 0);
      chk("bp_empty_count", s1_count, 0);

      // flush while FULL
      s1_out_ready = 1'b0;
      s1_in_valid  = 1'b1;
      s1_in_ctrl   = 18'd5; s1_in_data = DW'(32'hC5);
      tick();
      s1_in_ctrl   = 18'd6; s1_in_data = DW'(32'hC6);
      tick();
      chk("fl_full_count", s1_count, 2);
      s1_in_ctrl   = 18'd7; s1_in_data = DW'(32'hC7);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      s1_in_valid  = 1'b0;
      chk("fl_valid", s1_out_valid, 0);
      chk("fl_ctrl", s1_out_ctrl, 0);
      chk("fl_data", s1_out_data, 0);
      chk("fl_count", s1_count, 0);
      chk("fl_in_ready", s1_in_ready, 1);
      s1_out_ready = 1'b1;
      tick();
      chk("fl_no_ghost", s1_out_valid, 0);

      // flush while ONE with a same-cycle accept: the accept is discarded
      s1_out_ready = 1'b0;
      s1_in_valid  = 1'b1;
      s1_in_ctrl   = 18'd9; s1_in_data = DW'(32'hC9);
      tick();
      s1_in_ctrl   = 18'd10;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      s1_in_valid  = 1'b0;
      chk("fl1_count", s1_count, 0);
      chk("fl1_valid", s1_out_valid, 0);

      // reset mid-operation
      s1_in_valid = 1'b1;
      s1_in_ctrl  = 18'h3FFFF; s1_in_data = DW'(32'hD1);
      tick();
      s1_in_valid = 1'b0;
      chk("rm_count", s1_count, 1);
      chk("rm_ctrl", s1_out_ctrl, 256'h3FFFF);
      rst = 1'b1;
      tick();
      chk("rm_valid", s1_out_valid, 0);
      chk("rm_ctrl0", s1_out_ctrl, 0);
      chk("rm_in_ready", s1_in_ready, 0);
      rst = 1'b0;
      tick();
      chk("rm_in_ready_after", s1_in_ready, 1);
      chk("rm_count_after", s1_count, 0);

      // SKID=0 behaviour
      s0_out_ready = 1'b0;
      s0_in_valid  = 1'b1;
      s0_in_ctrl   = 18'h11; s0_in_data = DW'(32'hE1);
      tick();
      chk("s0_valid", s0_out_valid, 1);
      chk("s0_in_ready_stall", s0_in_ready, 0);
      s0_out_ready = 1'b1;
      s0_in_ctrl   = 18'h12; s0_in_data = DW'(32'hE2);
      #1;
      chk("s0_in_ready_go", s0_in_ready, 1);
      tick();
      chk("s0_replace_ctrl", s0_out_ctrl, 256'h12);
      chk("s0_replace_data", s0_out_data, 256'hE2);
      chk("s0_replace_count", s0_count, 1);
      s0_in_ctrl   = 18'h13; s0_in_data = DW'(32'hE3);
      tick();
      chk("s0_tput_ctrl", s0_out_ctrl, 256'h13);
      s0_in_valid  = 1'b0;
      tick();
      chk("s0_empty_valid", s0_out_valid, 0);
      chk("s0_empty_ctrl", s0_out_ctrl, 0);

      // random traffic against reference FIFOs, both instances
      for (int c = 0; c < 10000; c++) begin
         tick();
         chk("rnd1_bubble", (!s1_out_valid && s1_out_ctrl != '0), 0);
         chk("rnd0_bubble", (!s0_out_valid && s0_out_ctrl != '0), 0);
         chk("rnd1_count", s1_count, q1.size());
         chk("rnd0_count", s0_count, q0.size());
         s1_in_valid  = 1'($urandom);
         s1_out_ready = 1'($urandom);
         s1_in_ctrl   = CW'($urandom);
         s1_in_data   = rand_data();
         s0_in_valid  = 1'($urandom);
         s0_out_ready = 1'($urandom);
         s0_in_ctrl   = CW'($urandom);
         s0_in_data   = rand_data();
         @(negedge clk);
         if (s1_out_valid && s1_out_ready) begin
            if (q1.size() == 0) chk("rnd1_spurious", 1, 0);
            else chk("rnd1_order", {s1_out_ctrl, s1_out_data}, q1.pop_front());
         end
         if (s1_in_valid && s1_in_ready) q1.push_back({s1_in_ctrl, s1_in_data});
         if (s0_out_valid && s0_out_ready) begin
            if (q0.size() == 0) chk("rnd0_spurious", 1, 0);
            else chk("rnd0_order", {s0_out_ctrl, s0_out_data}, q0.pop_front());
         end
         if (s0_in_valid && s0_in_ready) q0.push_back({s0_in_ctrl, s0_in_data});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
